systolic_mm3_core: RTL and testbench

SYSTOLIC_MM3_CORE -- requirements
Module: systolic_mm3_core

---
 rtl/mm3_pkg.sv | 14 +
 rtl/systolic_mm3_core_if.sv | 27 ++
 rtl/mm3_pe.sv | 58 +++++
 rtl/systolic_mm3_core.sv | 162 ++++++++++++++++
 tb/tb_systolic_mm3_core.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mm3_pkg.sv
// Shared constants and FSM encoding for the 3x3 output-stationary systolic multiplier.
package mm3_pkg;
  localparam int N           = 3;
  localparam int DW          = 16;
  localparam int AW          = 32;
  localparam int FEED_CYCLES = 7;
  localparam int CNT_W       = $clog2(FEED_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/systolic_mm3_core_if.sv
// Request/result bundle of systolic_mm3_core; master drives operands, slave returns results.
interface systolic_mm3_core_if
  import mm3_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 32
);
  logic                  start;
  logic [N*N*DW-1:0]     a_flat;
  logic [N*N*DW-1:0]     b_flat;
  logic [N*N*DW-1:0]     bias_flat;
  logic signed [AW-1:0]  threshold;
  logic                  busy;
  logic                  done;
  logic [N*N*AW-1:0]     c_acc;
  logic [N*N-1:0]        c_bin;

  modport master (
    output start, a_flat, b_flat, bias_flat, threshold,
    input  busy, done, c_acc, c_bin
  );

  modport slave (
    input  start, a_flat, b_flat, bias_flat, threshold,
    output busy, done, c_acc, c_bin
  );
endinterface

// File: rtl/mm3_pe.sv
// Processing element: signed MAC with one-cycle a (east) and b (south) pass-through registers.
module mm3_pe #(
  parameter int DW = 16,
  parameter int AW = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 load,
  input  logic                 en,
  input  logic signed [AW-1:0] bias,
  input  logic signed [DW-1:0] a_in,
  input  logic signed [DW-1:0] b_in,
  output logic signed [DW-1:0] a_out,
  output logic signed [DW-1:0] b_out,
  output logic signed [AW-1:0] acc
);
  logic signed [DW-1:0]   a_q, a_d;
  logic signed [DW-1:0]   b_q, b_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic signed [2*DW-1:0] prod;

  // Full-precision product, sign-extended into the wrapping accumulator.
  always_comb begin
    prod  = a_in * b_in;
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    if (load) begin
      acc_d = bias;
    end else if (en) begin
      acc_d = acc_q + AW'(prod);
    end
    if (clr) begin
      a_d = '0;
      b_d = '0;
    end else if (en) begin
      a_d = a_in;
      b_d = b_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign acc   = acc_q;
endmodule

// File: rtl/systolic_mm3_core.sv
// 3x3 signed matrix multiply-accumulate C = A*B + bias on a 3x3 systolic array,
// with a binarised copy of C against a signed threshold.
module systolic_mm3_core #(
  parameter int DW = mm3_pkg::DW,
  parameter int AW = mm3_pkg::AW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [9*DW-1:0]      a_flat,
  input  logic [9*DW-1:0]      b_flat,
  input  logic [9*DW-1:0]      bias_flat,
  input  logic signed [AW-1:0] threshold,
  output logic                 busy,
  output logic                 done,
  output logic [9*AW-1:0]      c_acc,
  output logic [8:0]           c_bin
);
  import mm3_pkg::*;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [N*N*DW-1:0]     a_snap_q, a_snap_d;
  logic [N*N*DW-1:0]     b_snap_q, b_snap_d;
  logic signed [AW-1:0]  thr_q, thr_d;
  logic [N*N*AW-1:0]     c_acc_q, c_acc_d;
  logic [N*N-1:0]        c_bin_q, c_bin_d;
  logic                  done_q, done_d;
  logic                  load;
  logic                  run;

  logic signed [DW-1:0]  west  [N];
  logic signed [DW-1:0]  north [N];
  logic signed [DW-1:0]  a_w   [N][N];
  logic signed [DW-1:0]  b_w   [N][N];
  logic signed [AW-1:0]  acc_w [N*N];
  logic                  unused_edge;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_snap_d = a_snap_q;
    b_snap_d = b_snap_q;
    thr_d    = thr_q;
    c_acc_d  = c_acc_q;
    c_bin_d  = c_bin_q;
    done_d   = 1'b0;
    load     = 1'b0;
    run      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_snap_d = a_flat;
          b_snap_d = b_flat;
          thr_d    = threshold;
          cnt_d    = '0;
          load     = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        run = 1'b1;
        if (cnt_q == CNT_W'(FEED_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
        for (int k = 0; k < N * N; k++) begin
          c_acc_d[AW*k +: AW] = acc_w[k];
          c_bin_d[k]          = (acc_w[k] >= thr_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Diagonal skew: row i / column j enter i (resp. j) cycles late so operand pairs meet in PE(i,j).
  always_comb begin
    for (int i = 0; i < N; i++) begin
      west[i]  = '0;
      north[i] = '0;
      if (int'(cnt_q) >= i && int'(cnt_q) < i + N) begin
        west[i]  = a_snap_q[DW*(N*i + int'(cnt_q) - i) +: DW];
        north[i] = b_snap_q[DW*(N*(int'(cnt_q) - i) + i) +: DW];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_snap_q <= '0;
      b_snap_q <= '0;
      thr_q    <= '0;
      c_acc_q  <= '0;
      c_bin_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_snap_q <= a_snap_d;
      b_snap_q <= b_snap_d;
      thr_q    <= thr_d;
      c_acc_q  <= c_acc_d;
      c_bin_q  <= c_bin_d;
      done_q   <= done_d;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic signed [DW-1:0] a_in;
      logic signed [DW-1:0] b_in;
      logic signed [AW-1:0] bias_ext;

      if (j == 0) begin : g_west
        assign a_in = west[i];
      end else begin : g_chain_a
        assign a_in = a_w[i][j-1];
      end
      if (i == 0) begin : g_north
        assign b_in = north[j];
      end else begin : g_chain_b
        assign b_in = b_w[i-1][j];
      end
      assign bias_ext = AW'($signed(bias_flat[DW*(N*i + j) +: DW]));

      mm3_pe #(.DW(DW), .AW(AW)) u_pe (
        .clk   (clk),
        .rst   (rst),
        .clr   (load),
        .load  (load),
        .en    (run),
        .bias  (bias_ext),
        .a_in  (a_in),
        .b_in  (b_in),
        .a_out (a_w[i][j]),
        .b_out (b_w[i][j]),
        .acc   (acc_w[N*i + j])
      );
    end
  end

  // East and south edge outputs leave the array and feed nothing.
  always_comb begin
    unused_edge = 1'b0;
    for (int i = 0; i < N; i++) begin
      unused_edge = unused_edge ^ (^a_w[i][N-1]) ^ (^b_w[N-1][i]);
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign c_acc = c_acc_q;
  assign c_bin = c_bin_q;
endmodule

// File: tb/tb_systolic_mm3_core.sv
// Randomised bench for systolic_mm3_core against a timeline/arithmetic reference model.
module tb_systolic_mm3_core;
  localparam int DW    = 16;
  localparam int AW    = 32;
  localparam int W_IN  = 9 * DW;
  localparam int W_OUT = 9 * AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_mm3_core_if #(.DW(DW), .AW(AW)) bus ();

  systolic_mm3_core #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (bus.start),
    .a_flat    (bus.a_flat),
    .b_flat    (bus.b_flat),
    .bias_flat (bus.bias_flat),
    .threshold (bus.threshold),
    .busy      (bus.busy),
    .done      (bus.done),
    .c_acc     (bus.c_acc),
    .c_bin     (bus.c_bin)
  );

  int checks = 0;
  int errors = 0;
  int done_pulses = 0;

  bit               active   = 1'b0;
  int               cyc      = 0;
  int               acc_edge = 0;
  logic [W_OUT-1:0] exp_acc  = '0;
  logic [W_OUT-1:0] pend_acc = '0;
  logic [8:0]       exp_bin  = '0;
  logic [8:0]       pend_bin = '0;

  task automatic chk(input string nm, input logic [W_OUT-1:0] act, input logic [W_OUT-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  function automatic logic [W_OUT-1:0] mm(input logic [W_IN-1:0] a, input logic [W_IN-1:0] b,
                                          input logic [W_IN-1:0] bias);
    logic [W_OUT-1:0] r;
    longint s;
    shortint x, y;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        y = bias[DW*(3*i+j) +: DW];
        s = longint'(y);
        for (int k = 0; k < 3; k++) begin
          x = a[DW*(3*i+k) +: DW];
          y = b[DW*(3*k+j) +: DW];
          s = s + longint'(x) * longint'(y);
        end
        r[AW*(3*i+j) +: AW] = s[31:0];
      end
    end
    return r;
  endfunction

  function automatic logic [8:0] binz(input logic [W_OUT-1:0] c, input int thr);
    logic [8:0] r;
    int v;
    for (int k = 0; k < 9; k++) begin
      v = c[AW*k +: AW];
      r[k] = (v >= thr);
    end
    return r;
  endfunction

  // Reference timeline: accept at edge N when idle, results visible from edge N+8, idle again at N+9.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      active  = 1'b0;
      exp_acc = '0;
      exp_bin = '0;
    end else begin
      cyc++;
      if (active && (cyc - acc_edge) == 8) begin
        exp_acc = pend_acc;
        exp_bin = pend_bin;
      end
      if (active && (cyc - acc_edge) >= 9) active = 1'b0;
      if (!active && bus.start === 1'b1) begin
        active   = 1'b1;
        acc_edge = cyc;
        pend_acc = mm(bus.a_flat, bus.b_flat, bus.bias_flat);
        pend_bin = binz(pend_acc, bus.threshold);
      end
    end
  end

  always @(negedge clk) begin : cmp
    bit eb, ed;
    eb = active && (cyc - acc_edge) < 8;
    ed = active && (cyc - acc_edge) == 8;
    chk("busy",  W_OUT'(bus.busy), W_OUT'(eb));
    chk("done",  W_OUT'(bus.done), W_OUT'(ed));
    chk("c_acc", bus.c_acc, exp_acc);
    chk("c_bin", W_OUT'(bus.c_bin), W_OUT'(exp_bin));
    if (bus.done === 1'b1) done_pulses++;
  end

  task automatic launch(input logic [W_IN-1:0] a, input logic [W_IN-1:0] b,
                        input logic [W_IN-1:0] bias, input int thr);
    bus.a_flat    = a;
    bus.b_flat    = b;
    bus.bias_flat = bias;
    bus.threshold = thr;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done === 1'b1) return;
    end
    checks++;
    errors++;
    $display("FAIL done_timeout: got no done within %0d cycles, required one", lat);
  endtask

  task automatic rand_ops(output logic [W_IN-1:0] a, output logic [W_IN-1:0] b,
                          output logic [W_IN-1:0] bias, output int thr);
    for (int k = 0; k < 9; k++) begin
      a[DW*k +: DW]    = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
      b[DW*k +: DW]    = ($urandom_range(0, 7) == 0) ? 16'h7FFF : 16'($urandom);
      bias[DW*k +: DW] = 16'($urandom);
    end
    thr = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom);
  endtask

  task automatic run_check(input string nm, input logic [W_IN-1:0] a, input logic [W_IN-1:0] b,
                           input logic [W_IN-1:0] bias, input int thr,
                           input logic [W_OUT-1:0] lit_acc, input logic [8:0] lit_bin);
    int lat;
    chk({nm, "_model_acc"}, mm(a, b, bias), lit_acc);
    chk({nm, "_model_bin"}, W_OUT'(binz(lit_acc, thr)), W_OUT'(lit_bin));
    launch(a, b, bias, thr);
    wait_done(lat);
    chk({nm, "_latency"}, W_OUT'(lat), W_OUT'(8));
    chk({nm, "_acc"}, bus.c_acc, lit_acc);
    chk({nm, "_bin"}, W_OUT'(bus.c_bin), W_OUT'(lit_bin));
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no end of test, required $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [W_IN-1:0]  a, b, bias, a2, b2, bias2, ax, bx, biasx;
    logic [W_OUT-1:0] lit, r1;
    int thr, thr2, thrx, lat, p0;

    bus.start     = 1'b0;
    bus.a_flat    = '0;
    bus.b_flat    = '0;
    bus.bias_flat = '0;
    bus.threshold = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  W_OUT'(bus.busy), '0);
    chk("rst_done",  W_OUT'(bus.done), '0);
    chk("rst_c_acc", bus.c_acc, '0);
    chk("rst_c_bin", W_OUT'(bus.c_bin), '0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Identity times 1..9
    a = '0; b = '0; bias = '0;
    for (int i = 0; i < 3; i++) begin
      a[DW*(4*i) +: DW] = 16'd1;
      for (int j = 0; j < 3; j++) b[DW*(3*i+j) +: DW] = 16'(3*i + j + 1);
    end
    lit = {32'd9, 32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    run_check("eye", a, b, bias, 5, lit, 9'h1F0);

    // Most-negative operands wrap the accumulator
    run_check("wrap", {9{16'h8000}}, {9{16'h8000}}, '0, 0, {9{32'hC0000000}}, 9'h000);

    // Bias only, two thresholds
    for (int k = 0; k < 9; k++) bias[DW*k +: DW] = 16'(k - 4);
    lit = {32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFC};
    run_check("bias_t0", '0, '0, bias, 0, lit, 9'h1F0);
    run_check("bias_tm70", '0, '0, bias, -70, lit, 9'h1FF);

    // Second start mid-run is ignored
    rand_ops(a, b, bias, thr);
    rand_ops(a2, b2, bias2, thr2);
    r1 = mm(a, b, bias);
    p0 = done_pulses;
    launch(a, b, bias, thr);
    repeat (3) @(posedge clk);
    #1;
    launch(a2, b2, bias2, thr2);
    wait_done(lat);
    chk("ignore_latency", W_OUT'(lat), W_OUT'(4));
    chk("ignore_acc", bus.c_acc, r1);
    chk("ignore_bin", W_OUT'(bus.c_bin), W_OUT'(binz(r1, thr)));
    repeat (12) @(posedge clk);
    #1;
    chk("ignore_pulses", W_OUT'(done_pulses - p0), W_OUT'(1));

    // Asynchronous abort mid-run
    rand_ops(a, b, bias, thr);
    launch(a, b, bias, thr);
    repeat (3) @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy",  W_OUT'(bus.busy), '0);
    chk("abort_done",  W_OUT'(bus.done), '0);
    chk("abort_c_acc", bus.c_acc, '0);
    chk("abort_c_bin", W_OUT'(bus.c_bin), '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    p0 = done_pulses;
    repeat (14) @(posedge clk);
    #1;
    chk("abort_no_done", W_OUT'(done_pulses - p0), '0);
    rand_ops(a, b, bias, thr);
    r1 = mm(a, b, bias);
    launch(a, b, bias, thr);
    wait_done(lat);
    chk("post_abort_latency", W_OUT'(lat), W_OUT'(8));
    chk("post_abort_acc", bus.c_acc, r1);

    // Start accepted in the done cycle
    rand_ops(a2, b2, bias2, thr2);
    launch(a2, b2, bias2, thr2);
    chk("b2b_hold_acc", bus.c_acc, r1);
    wait_done(lat);
    chk("b2b_latency", W_OUT'(lat), W_OUT'(8));
    chk("b2b_acc", bus.c_acc, mm(a2, b2, bias2));
    chk("b2b_bin", W_OUT'(bus.c_bin), W_OUT'(binz(mm(a2, b2, bias2), thr2)));
    @(posedge clk);
    #1;

    // Random traffic: input scrambling, stray starts, gaps and back-to-back starts
    for (int t = 0; t < 24; t++) begin
      rand_ops(a, b, bias, thr);
      r1 = mm(a, b, bias);
      launch(a, b, bias, thr);
      rand_ops(ax, bx, biasx, thrx);
      bus.a_flat    = ax;
      bus.b_flat    = bx;
      bus.bias_flat = biasx;
      bus.threshold = thrx;
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 5)) @(posedge clk);
        #1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
      end
      wait_done(lat);
      chk("rand_acc", bus.c_acc, r1);
      chk("rand_bin", W_OUT'(bus.c_bin), W_OUT'(binz(r1, thr)));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end

    repeat (12) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
